hash_in_packer: RTL and testbench
=================================

Name: hash_in_packer

Overview:
- Upstream feeder for the SHA3 hash stages in the pre-encrypt path.
- Accepts the message/seed material (for example m || H(pk) for G) as a stream of WORD_W-bit words over valid/ready.
- Packs the words into one IN_WIDTH-bit block, pulses the hash start, holds the block stable, then captures the digest and presents it downstream over valid/ready.

Parameters:
- WORD_W, 32, stream word width in bits.
- IN_WIDTH, 512, packed block width driven to the hash (2*KYBER_N). Must be a multiple of WORD_W.
- OUT_WIDTH, 512, digest width captured from the hash.

Ports:
- clk  input  1  single clock; all logic on posedge.
- rst_n  input  1  synchronous active-low reset.
- s_valid  input  1  input word valid.
- s_ready  output  1  packer can accept a word.
- s_data  input  WORD_W  input word.
- s_last  input  1  marks the final word of the message.
- hash_start  output  1  one-cycle start pulse to the hash.
- hash_in  output  IN_WIDTH  packed block; stable from the start pulse until the digest is consumed.
- hash_valid  input  1  digest valid from the hash.
- hash_out  input  OUT_WIDTH  digest from the hash.
- m_valid  output  1  digest available.
- m_ready  input  1  downstream accepts the digest.
- m_data  output  OUT_WIDTH  registered digest.
- m_short  output  1  message ended before the block was full; remainder is zero-padded.

Behaviour:
- Interface: one clock, clk. Reset rst_n is synchronous and active-low.
- Reset (rst_n=0 at posedge):
  - state = FILL, word count = 0, hash_in = 0.
  - hash_start = 0, m_valid = 0, m_data = 0, m_short = 0, s_ready = 1 on the following cycle.
- Reset takes effect in any state, including mid-fill or WAIT. The block is discarded, and a hash_valid arriving afterwards is ignored.
- Let NW = IN_WIDTH/WORD_W (16 by default).
- FILL:
  - s_ready = 1.
  - A word is accepted on s_valid & s_ready. Word k is written to hash_in[k*WORD_W +: WORD_W], so word 0 occupies the LSBs. The count then increments.
  - Go to START when the NW-th word is accepted (count wraps to 0), with or without s_last.
  - Go to START when s_last is accepted with count < NW-1. The remaining words stay zero and m_short is set to 1.
- START:
  - hash_start = 1 for exactly this one cycle; s_ready = 0.
  - Next state is WAIT.
- WAIT:
  - hash_start = 0, s_ready = 0.
  - On hash_valid=1: capture hash_out into m_data, set m_valid = 1, go to OUT.
  - hash_valid during FILL, START or OUT is ignored.
  - A hash_valid arriving in the cycle directly after the start pulse (a one-cycle hash) is captured.
  - No timeout.
- OUT:
  - m_valid = 1; m_data and m_short are held stable while m_ready = 0.
  - On m_valid & m_ready: m_valid = 0, hash_in cleared to 0, m_short cleared, count = 0, go to FILL.
  - s_ready rises in the cycle after the handshake.
- Throughput:
  - Minimum NW+3 cycles per block with a one-cycle hash and m_ready held high.
  - Latency from the last accepted word to m_valid is 3 cycles with a one-cycle hash: START, WAIT, then m_valid visible.
- A word with s_valid=1 while s_ready=0 is not consumed; the source holds it.
- s_last with count = NW-1 is a normal full block; m_short = 0.

Test Plan:
- Full block: 16 words 0x00000000..0x0000000F, s_last on word 15, hash model echoes hash_in after 1 cycle.
  - Expect exactly one hash_start pulse.
  - Expect hash_in[31:0]=0x0, hash_in[511:480]=0xF.
  - Expect m_data = that block, m_short=0, m_valid 3 cycles after the last word.
- Short message: 8 words 0xA5A5A5A5 with s_last on word 7.
  - Expect hash_in[255:0] all 0xA5A5A5A5 and hash_in[511:256]=0.
  - Expect m_short=1.
- Backpressure: hold m_ready=0 for 10 cycles in OUT.
  - m_valid, m_data and m_short stay stable; s_ready stays 0.
  - After the handshake, s_ready=1 next cycle; a second block of 16 words 0xFFFFFFFF yields m_data all ones.
- Slow hash: hash model returns hash_valid 20 cycles after the start pulse, and a spurious hash_valid is driven during FILL.
  - The spurious pulse is ignored.
  - The digest is captured only in WAIT.
  - hash_in is unchanged throughout.
- Reset mid-operation: assert rst_n=0 for 1 cycle after 5 words, then again during WAIT.
  - Each time, outputs return to reset values and the count restarts at 0.
  - A late hash_valid produces no m_valid.
- Input stall: toggle s_valid randomly over 16 words.
  - Word order in hash_in is preserved.
  - No word is lost or duplicated; the result matches the golden block.

Source files
------------

// File: rtl/hash_in_packer.sv
// Packs a valid/ready word stream into one hash input block, starts the hash,
// then captures the digest and offers it downstream over valid/ready.
module hash_in_packer #(
    parameter int unsigned WORD_W    = 32,
    parameter int unsigned IN_WIDTH  = 512,
    parameter int unsigned OUT_WIDTH = 512
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 s_valid,
    output logic                 s_ready,
    input  logic [WORD_W-1:0]    s_data,
    input  logic                 s_last,
    output logic                 hash_start,
    output logic [IN_WIDTH-1:0]  hash_in,
    input  logic                 hash_valid,
    input  logic [OUT_WIDTH-1:0] hash_out,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic [OUT_WIDTH-1:0] m_data,
    output logic                 m_short
);

    localparam int unsigned NW    = IN_WIDTH / WORD_W;
    localparam int unsigned CNT_W = (NW > 1) ? $clog2(NW) : 1;

    typedef enum logic [1:0] {
        FILL  = 2'd0,
        START = 2'd1,
        WAIT  = 2'd2,
        OUT   = 2'd3
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] count;
    logic             accept_c;
    logic             block_end_c;

    assign accept_c    = s_valid & s_ready;
    assign block_end_c = (count == CNT_W'(NW - 1)) | s_last;

    // Single-process FSM; every output is a register updated here.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= FILL;
            count      <= '0;
            hash_in    <= '0;
            hash_start <= 1'b0;
            s_ready    <= 1'b1;
            m_valid    <= 1'b0;
            m_data     <= '0;
            m_short    <= 1'b0;
        end else begin
            hash_start <= 1'b0;
            case (state)
                FILL: begin
                    if (accept_c) begin
                        for (int unsigned k = 0; k < NW; k++) begin
                            if (count == CNT_W'(k)) begin
                                hash_in[k*WORD_W +: WORD_W] <= s_data;
                            end
                        end
                        if (block_end_c) begin
                            // Unwritten words were cleared on the previous handshake, so padding is free.
                            m_short    <= (count != CNT_W'(NW - 1));
                            count      <= '0;
                            s_ready    <= 1'b0;
                            hash_start <= 1'b1;
                            state      <= START;
                        end else begin
                            count <= count + CNT_W'(1);
                        end
                    end
                end
                START: begin
                    state <= WAIT;
                end
                WAIT: begin
                    if (hash_valid) begin
                        m_data  <= hash_out;
                        m_valid <= 1'b1;
                        state   <= OUT;
                    end
                end
                OUT: begin
                    if (m_ready) begin
                        m_valid <= 1'b0;
                        m_short <= 1'b0;
                        hash_in <= '0;
                        count   <= '0;
                        s_ready <= 1'b1;
                        state   <= FILL;
                    end
                end
                default: begin
                    state <= FILL;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hash_in_packer.sv
// Scoreboard bench for hash_in_packer: an echo hash model with programmable
// latency, expected digests queued at stimulus time and popped on m handshakes.
`timescale 1ns/1ps
module tb_hash_in_packer;

    localparam int unsigned WORD_W    = 32;
    localparam int unsigned IN_WIDTH  = 512;
    localparam int unsigned OUT_WIDTH = 512;
    localparam int          NW        = 16;

    typedef logic [OUT_WIDTH-1:0] val_t;
    typedef logic [IN_WIDTH-1:0]  blk_t;
    typedef struct {
        val_t data;
        logic short_f;
    } exp_t;

    logic              clk        = 1'b0;
    logic              rst_n      = 1'b0;
    logic              s_valid    = 1'b0;
    logic              s_last     = 1'b0;
    logic              m_ready    = 1'b0;
    logic              hash_valid = 1'b0;
    logic              spur       = 1'b0;
    logic [WORD_W-1:0] s_data     = '0;
    val_t              hash_out   = '0;
    logic              s_ready;
    logic              hash_start;
    logic              m_valid;
    logic              m_short;
    blk_t              hash_in;
    val_t              m_data;

    int n_cmp    = 0;
    int n_err    = 0;
    int n_start  = 0;
    int hash_lat = 1;
    int pend     = 0;
    blk_t              pend_data = '0;
    logic [WORD_W-1:0] wbuf [NW];
    exp_t              sb [$];

    always #5 clk = ~clk;

    hash_in_packer #(
        .WORD_W   (WORD_W),
        .IN_WIDTH (IN_WIDTH),
        .OUT_WIDTH(OUT_WIDTH)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .s_data    (s_data),
        .s_last    (s_last),
        .hash_start(hash_start),
        .hash_in   (hash_in),
        .hash_valid(hash_valid),
        .hash_out  (hash_out),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_data    (m_data),
        .m_short   (m_short)
    );

    task automatic check(input string tag, input val_t got, input val_t exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Echo hash: returns the sampled block hash_lat cycles after the start pulse; spur injects garbage.
    always @(posedge clk) begin
        hash_valid <= spur;
        if (spur) hash_out <= {16{32'hDEADBEEF}};
        if (hash_start) begin
            pend_data <= hash_in;
            if (hash_lat <= 1) begin
                hash_valid <= 1'b1;
                hash_out   <= hash_in;
                pend       <= 0;
            end else begin
                pend <= hash_lat - 1;
            end
        end else if (pend > 0) begin
            pend <= pend - 1;
            if (pend == 1) begin
                hash_valid <= 1'b1;
                hash_out   <= pend_data;
            end
        end
    end

    // Output monitor, sampled just after the falling edge.
    always @(negedge clk) begin
        exp_t e;
        #1;
        if (hash_start) n_start++;
        if (rst_n && m_valid && m_ready) begin
            if (sb.size() == 0) begin
                check("unexpected_m_valid", val_t'(m_valid), val_t'(0));
            end else begin
                e = sb.pop_front();
                check("m_data", m_data, e.data);
                check("m_short", val_t'(m_short), val_t'(e.short_f));
            end
        end
    end

    function automatic blk_t exp_block(input int n);
        blk_t b = '0;
        for (int k = 0; k < n; k++) b[k*WORD_W +: WORD_W] = wbuf[k];
        return b;
    endfunction

    task automatic send_word(input logic [WORD_W-1:0] d, input logic last, input bit stall);
        int t = 0;
        if (stall) begin
            while ($urandom_range(0, 1) == 1) begin
                s_valid = 1'b0;
                @(negedge clk);
            end
        end
        s_valid = 1'b1;
        s_data  = d;
        s_last  = last;
        while (!s_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (!s_ready) check("s_ready_timeout", val_t'(s_ready), val_t'(1));
        else @(negedge clk);
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic send_block(input int n, input bit stall, input bit push, input int spur_at);
        exp_t e;
        if (push) begin
            e.data    = val_t'(exp_block(n));
            e.short_f = (n < NW);
            sb.push_back(e);
        end
        for (int k = 0; k < n; k++) begin
            if (k == spur_at) begin
                spur = 1'b1;
                @(negedge clk);
                spur = 1'b0;
            end
            send_word(wbuf[k], (k == n - 1), stall);
        end
    endtask

    task automatic wait_mvalid(input string tag);
        int t = 0;
        while (!m_valid && t < 100) begin
            @(negedge clk);
            t++;
        end
        check(tag, val_t'(m_valid), val_t'(1));
    endtask

    task automatic wait_ready(input string tag);
        int t = 0;
        while (!(s_ready && !m_valid) && t < 100) begin
            @(negedge clk);
            t++;
        end
        check(tag, val_t'(s_ready), val_t'(1));
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_s_ready"}, val_t'(s_ready), val_t'(1));
        check({tag, "_hash_start"}, val_t'(hash_start), val_t'(0));
        check({tag, "_m_valid"}, val_t'(m_valid), val_t'(0));
        check({tag, "_m_short"}, val_t'(m_short), val_t'(0));
        check({tag, "_hash_in"}, val_t'(hash_in), val_t'(0));
    endtask

    initial begin
        blk_t exp_b;
        int   n0;
        int   t;

        // Reset values
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        check_reset_outputs("rst");
        check("rst_m_data", m_data, val_t'(0));

        // Full block, one-cycle hash, latency and slot placement
        m_ready  = 1'b1;
        hash_lat = 1;
        for (int k = 0; k < NW; k++) wbuf[k] = WORD_W'(k);
        n0 = n_start;
        send_block(NW, 1'b0, 1'b1, -1);
        check("t1_start", val_t'(hash_start), val_t'(1));
        check("t1_word0", val_t'(hash_in[31:0]), val_t'(32'h0));
        check("t1_word15", val_t'(hash_in[511:480]), val_t'(32'hF));
        check("t1_lat_start", val_t'(m_valid), val_t'(0));
        @(negedge clk);
        check("t1_lat_wait", val_t'(m_valid), val_t'(0));
        @(negedge clk);
        check("t1_lat_valid", val_t'(m_valid), val_t'(1));
        wait_ready("t1_ready");
        check("t1_one_start", val_t'(n_start - n0), val_t'(1));

        // Short message, then downstream backpressure in OUT
        m_ready = 1'b0;
        for (int k = 0; k < NW; k++) wbuf[k] = 32'hA5A5A5A5;
        send_block(8, 1'b0, 1'b1, -1);
        check("t2_low_half", val_t'(hash_in[255:0]), val_t'({8{32'hA5A5A5A5}}));
        check("t2_high_half", val_t'(hash_in[511:256]), val_t'(0));
        exp_b = exp_block(8);
        wait_mvalid("t2_m_valid");
        for (int c = 0; c < 10; c++) begin
            check("t3_hold_valid", val_t'(m_valid), val_t'(1));
            check("t3_hold_data", m_data, val_t'(exp_b));
            check("t3_hold_short", val_t'(m_short), val_t'(1));
            check("t3_hold_s_ready", val_t'(s_ready), val_t'(0));
            @(negedge clk);
        end
        m_ready = 1'b1;
        @(negedge clk);
        check("t3_s_ready_after", val_t'(s_ready), val_t'(1));
        check("t3_m_valid_after", val_t'(m_valid), val_t'(0));
        for (int k = 0; k < NW; k++) wbuf[k] = 32'hFFFFFFFF;
        send_block(NW, 1'b0, 1'b1, -1);
        wait_ready("t3_ready");

        // Slow hash with a spurious hash_valid during FILL
        hash_lat = 20;
        for (int k = 0; k < NW; k++) wbuf[k] = WORD_W'(k) * 32'h01010101 + 32'h10000000;
        n0 = n_start;
        send_block(NW, 1'b0, 1'b1, 4);
        exp_b = exp_block(NW);
        t = 0;
        while (!m_valid && t < 60) begin
            check("t4_hash_in_stable", val_t'(hash_in), val_t'(exp_b));
            @(negedge clk);
            t++;
        end
        check("t4_m_valid", val_t'(m_valid), val_t'(1));
        check("t4_one_start", val_t'(n_start - n0), val_t'(1));
        wait_ready("t4_ready");

        // Reset after 5 words, then a fresh block must start at word 0
        hash_lat = 1;
        for (int k = 0; k < NW; k++) wbuf[k] = 32'h50000000 | WORD_W'(k);
        for (int k = 0; k < 5; k++) send_word(wbuf[k], 1'b0, 1'b0);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check_reset_outputs("t5_rst_fill");
        for (int k = 0; k < NW; k++) wbuf[k] = 32'h60000000 + WORD_W'(k);
        send_block(NW, 1'b0, 1'b1, -1);
        wait_ready("t5_ready_a");

        // Reset during WAIT; the late hash_valid must not produce m_valid
        hash_lat = 5;
        send_block(NW, 1'b0, 1'b0, -1);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check_reset_outputs("t5_rst_wait");
        for (int c = 0; c < 10; c++) begin
            check("t5_no_m_valid", val_t'(m_valid), val_t'(0));
            @(negedge clk);
        end
        hash_lat = 1;
        for (int k = 0; k < NW; k++) wbuf[k] = 32'h70000000 + WORD_W'(k);
        send_block(NW, 1'b0, 1'b1, -1);
        wait_ready("t5_ready_b");

        // Random s_valid stalls over a full block
        for (int k = 0; k < NW; k++) wbuf[k] = $urandom;
        send_block(NW, 1'b1, 1'b1, -1);
        wait_ready("t6_ready");

        t = 0;
        while (sb.size() != 0 && t < 200) begin
            @(negedge clk);
            t++;
        end
        check("sb_drain", val_t'(sb.size()), val_t'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
